// File: rtl/dcfifo_rd_packer.sv
// dcfifo_rd_packer: read-side drain stage for a show-ahead dcfifo.
// Pops words whenever the FIFO has data and downstream room allows.
// Packs PACK consecutive words into one wide beat, with m_last on
// every BURST_LEN-th beat.
// Optional feature macro: DCFIFO_RD_SEQ_CHK_EN compiles in a popped-word
// sequence checker driving seq_err. Without it, seq_err is tied low.
module dcfifo_rd_packer #(
  parameter int DWIDTH    = 12,
  parameter int PACK      = 2,
  parameter int BURST_LEN = 16
) (
  input  logic                     rdclk,
  input  logic                     rst,
  input  logic [DWIDTH-1:0]        fifo_q,
  input  logic                     fifo_rdempty,
  output logic                     fifo_rdreq,
  output logic [DWIDTH*PACK-1:0]   m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     m_last,
  output logic [15:0]              beat_cnt,
  output logic                     seq_err
);

  localparam int LW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(PACK - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  logic [LW-1:0]          lane;
  logic [BW-1:0]          burst_idx;
  logic                   pop_last;
  logic [DWIDTH*PACK-1:0] beat_next;

  // The final-lane pop is the only one that needs room in the output
  // register; earlier lanes can always fill the accumulator.
  assign fifo_rdreq = !rst && !fifo_rdempty &&
                      (lane != LAST_LANE || !m_valid || m_ready);
  assign pop_last   = fifo_rdreq && (lane == LAST_LANE);

  generate
    if (PACK > 1) begin : g_acc
      logic [DWIDTH*(PACK-1)-1:0] acc;

      // Capture each non-final word into its lane of the accumulator.
      always_ff @(posedge rdclk) begin
        if (rst) begin
          acc <= '0;
        end else if (fifo_rdreq && !pop_last) begin
          for (int i = 0; i < PACK - 1; i++) begin
            if (lane == LW'(i)) begin
              acc[i*DWIDTH +: DWIDTH] <= fifo_q;
            end
          end
        end
      end

      assign beat_next = {fifo_q, acc};
    end else begin : g_no_acc
      assign beat_next = fifo_q;
    end
  endgenerate

  // Lane tracking, beat formation, output handshake and beat counting.
  always_ff @(posedge rdclk) begin
    if (rst) begin
      lane      <= '0;
      burst_idx <= '0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      if (fifo_rdreq) begin
        if (pop_last) begin
          lane      <= '0;
          m_data    <= beat_next;
          m_last    <= (burst_idx == LAST_BEAT);
          burst_idx <= (burst_idx == LAST_BEAT) ? '0 : burst_idx + BW'(1);
        end else begin
          lane <= lane + LW'(1);
        end
      end
      if (pop_last) begin
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      if (m_valid && m_ready) begin
        beat_cnt <= beat_cnt + 16'd1;
      end
    end
  end

`ifdef DCFIFO_RD_SEQ_CHK_EN
  logic              seeded;
  logic [DWIDTH-1:0] prev_word;

  // Each popped word must follow the previous one by +1; a value of 1
  // restarts the count, and the first pop after reset only seeds it.
  always_ff @(posedge rdclk) begin
    if (rst) begin
      seeded    <= 1'b0;
      prev_word <= '0;
      seq_err   <= 1'b0;
    end else if (fifo_rdreq) begin
      seeded    <= 1'b1;
      prev_word <= fifo_q;
      if (seeded && fifo_q != DWIDTH'(1) && fifo_q != prev_word + DWIDTH'(1)) begin
        seq_err <= 1'b1;
      end
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_dcfifo_rd_packer.sv
// tb_dcfifo_rd_packer: randomized and directed bench for dcfifo_rd_packer
// (PACK=2, BURST_LEN=4), using a queue-based FIFO and a word-grouping model.
// Honors DCFIFO_RD_SEQ_CHK_EN when deciding the expected seq_err.
module tb_dcfifo_rd_packer;
  localparam int DW = 12;
  localparam int PK = 2;
  localparam int BL = 4;
  localparam int BW = DW * PK;
`ifdef DCFIFO_RD_SEQ_CHK_EN
  localparam bit SEQ_CHK = 1'b1;
`else
  localparam bit SEQ_CHK = 1'b0;
`endif

  logic          tb_wclk = 1'b0;
  logic          rst;
  logic [DW-1:0] fifo_q;
  logic          fifo_rdempty;
  logic          fifo_rdreq;
  logic [BW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic [15:0]   beat_cnt;
  logic          seq_err;

  dcfifo_rd_packer #(.DWIDTH(DW), .PACK(PK), .BURST_LEN(BL)) dut (
    .rdclk(tb_wclk), .rst(rst), .fifo_q(fifo_q), .fifo_rdempty(fifo_rdempty),
    .fifo_rdreq(fifo_rdreq), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .beat_cnt(beat_cnt), .seq_err(seq_err)
  );

  // Free-running read clock.
  always #5 tb_wclk = ~tb_wclk;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] wq[$];
  bit            hold_empty;

  logic [DW-1:0] pend[$];
  logic [BW-1:0] exp_beats[$];
  bit            exp_lasts[$];
  int            formed;
  logic [15:0]   exp_cnt;
  bit            exp_err;
  bit            seeded;
  logic [DW-1:0] prev;

  logic [BW-1:0] obs[$];
  bit            obs_last[$];
  bit            last_rdreq;

  logic [BW-1:0] ref_beats[4];

  task automatic model_reset();
    pend.delete();
    exp_beats.delete();
    exp_lasts.delete();
    formed  = 0;
    exp_cnt = '0;
    exp_err = 1'b0;
    seeded  = 1'b0;
    prev    = '0;
  endtask

  function automatic logic [BW-1:0] pack_beat();
    logic [BW-1:0] b;
    b = '0;
    for (int i = 0; i < PK; i++) b[i*DW +: DW] = pend[i];
    return b;
  endfunction

  task automatic load_words(input int first, input int count);
    wq.delete();
    for (int i = 0; i < count; i++) wq.push_back(DW'(first + i));
  endtask

  task automatic clk_cycle();
    logic          exp_rdreq;
    logic          p_rd, p_mv, p_mr, p_ml, p_rst;
    logic [BW-1:0] p_md;
    logic [DW-1:0] w;
    fifo_rdempty = (wq.size() == 0) || hold_empty;
    fifo_q       = (wq.size() != 0) ? wq[0] : DW'($urandom);
    #1;
    p_rd = fifo_rdreq; p_mv = m_valid; p_mr = m_ready; p_ml = m_last;
    p_md = m_data; p_rst = rst;
    exp_rdreq = !p_rst && !fifo_rdempty &&
                !(pend.size() == PK - 1 && exp_beats.size() != 0 && !p_mr);
    vectors++;
    if (p_rd !== exp_rdreq) begin
      miscompares++;
      $display("[TB] FAIL rdreq: got %b expected %b at %0t", p_rd, exp_rdreq, $time);
    end
    vectors++;
    if (p_mv !== (exp_beats.size() != 0)) begin
      miscompares++;
      $display("[TB] FAIL m_valid: got %b expected %b at %0t", p_mv, exp_beats.size() != 0, $time);
    end
    if (exp_beats.size() != 0) begin
      vectors++;
      if (p_md !== exp_beats[0]) begin
        miscompares++;
        $display("[TB] FAIL m_data: got %h expected %h at %0t", p_md, exp_beats[0], $time);
      end
      vectors++;
      if (p_ml !== exp_lasts[0]) begin
        miscompares++;
        $display("[TB] FAIL m_last: got %b expected %b at %0t", p_ml, exp_lasts[0], $time);
      end
    end
    last_rdreq = p_rd;
    @(posedge tb_wclk);
    if (p_rst) begin
      model_reset();
    end else begin
      if (p_mv && p_mr && exp_beats.size() != 0) begin
        obs.push_back(p_md);
        obs_last.push_back(p_ml);
        void'(exp_beats.pop_front());
        void'(exp_lasts.pop_front());
        exp_cnt = exp_cnt + 16'd1;
      end
      if (p_rd && wq.size() != 0) begin
        w = wq.pop_front();
        if (seeded && w != DW'(1) && w != prev + DW'(1)) exp_err = 1'b1;
        seeded = 1'b1;
        prev   = w;
        pend.push_back(w);
        if (pend.size() == PK) begin
          exp_beats.push_back(pack_beat());
          exp_lasts.push_back((formed % BL) == BL - 1);
          formed++;
          pend.delete();
        end
      end
    end
    #1;
    vectors++;
    if (beat_cnt !== exp_cnt) begin
      miscompares++;
      $display("[TB] FAIL beat_cnt: got %0d expected %0d at %0t", beat_cnt, exp_cnt, $time);
    end
    vectors++;
    if (seq_err !== (SEQ_CHK && exp_err)) begin
      miscompares++;
      $display("[TB] FAIL seq_err: got %b expected %b at %0t", seq_err, SEQ_CHK && exp_err, $time);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    clk_cycle();
    rst = 1'b0;
    obs.delete();
    obs_last.delete();
  endtask

  task automatic check_ref_beats(input string tag);
    vectors++;
    if (obs.size() != 4) begin
      miscompares++;
      $display("[TB] FAIL %s beat count: got %0d expected 4", tag, obs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (obs[i] !== ref_beats[i] || obs_last[i] !== (i == 3)) begin
          miscompares++;
          $display("[TB] FAIL %s beat %0d: got %h/%b expected %h/%b", tag, i,
                   obs[i], obs_last[i], ref_beats[i], i == 3);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; m_ready = 1'b1; hold_empty = 1'b0;
    load_words(1, 2);
    fifo_rdempty = 1'b0; fifo_q = wq[0];
    repeat (2) @(posedge tb_wclk);
    #1;
    model_reset();
    vectors++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0 ||
        beat_cnt !== 16'd0 || seq_err !== 1'b0 || fifo_rdreq !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset state: got v=%b l=%b d=%h c=%0d e=%b rd=%b expected all 0",
               m_valid, m_last, m_data, beat_cnt, seq_err, fifo_rdreq);
    end
    clk_cycle();
    rst = 1'b0;
  endtask

  task automatic test_full_rate();
    int run;
    reset_dut();
    load_words(1, 8);
    m_ready = 1'b1;
    run = 0;
    for (int i = 0; i < 8; i++) begin
      clk_cycle();
      if (last_rdreq) run++;
    end
    vectors++;
    if (run != 8) begin
      miscompares++;
      $display("[TB] FAIL full_rate pops: got %0d expected 8", run);
    end
    repeat (3) clk_cycle();
    check_ref_beats("full_rate");
    vectors++;
    if (beat_cnt !== 16'd4) begin
      miscompares++;
      $display("[TB] FAIL full_rate beat_cnt: got %0d expected 4", beat_cnt);
    end
  endtask

  task automatic test_backpressure();
    reset_dut();
    load_words(1, 8);
    m_ready = 1'b1;
    repeat (2) clk_cycle();
    m_ready = 1'b0;
    repeat (4) clk_cycle();
    vectors++;
    if (wq.size() == 0 || wq[0] !== DW'(4) || fifo_rdreq !== 1'b0 || m_data !== 24'h002001) begin
      miscompares++;
      $display("[TB] FAIL backpressure hold: got head=%0d rd=%b d=%h expected head=4 rd=0 d=002001",
               (wq.size() != 0) ? wq[0] : '0, fifo_rdreq, m_data);
    end
    m_ready = 1'b1;
    repeat (10) clk_cycle();
    check_ref_beats("backpressure");
  endtask

  task automatic test_empty_gaps();
    reset_dut();
    load_words(1, 8);
    m_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      hold_empty = (i % 2) == 1;
      clk_cycle();
    end
    hold_empty = 1'b0;
    check_ref_beats("empty_gaps");
  endtask

  task automatic test_reset_mid();
    reset_dut();
    load_words(1, 16);
    m_ready = 1'b1;
    repeat (3) clk_cycle();
    rst = 1'b1;
    clk_cycle();
    rst = 1'b0;
    vectors++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_data !== '0 || beat_cnt !== 16'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid state: got v=%b l=%b d=%h c=%0d expected all 0",
               m_valid, m_last, m_data, beat_cnt);
    end
    obs.delete();
    obs_last.delete();
    repeat (12) clk_cycle();
    vectors++;
    if (obs.size() < 4 || obs[0] !== 24'h005004 ||
        obs_last[0] || obs_last[1] || obs_last[2] || !obs_last[3]) begin
      miscompares++;
      $display("[TB] FAIL reset_mid restart: got n=%0d first=%h expected first=005004 last on beat 4",
               obs.size(), (obs.size() != 0) ? obs[0] : '0);
    end
  endtask

  task automatic test_seq_check();
    reset_dut();
    wq.delete();
    wq.push_back(DW'(1)); wq.push_back(DW'(2)); wq.push_back(DW'(3)); wq.push_back(DW'(5));
    m_ready = 1'b1;
    repeat (3) clk_cycle();
    vectors++;
    if (seq_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL seq_early: got %b expected 0", seq_err);
    end
    clk_cycle();
    vectors++;
    if (seq_err !== SEQ_CHK) begin
      miscompares++;
      $display("[TB] FAIL seq_gap: got %b expected %b", seq_err, SEQ_CHK);
    end
    reset_dut();
    wq.delete();
    wq.push_back(DW'(1)); wq.push_back(DW'(2)); wq.push_back(DW'(3));
    wq.push_back(DW'(1)); wq.push_back(DW'(2));
    repeat (6) clk_cycle();
    vectors++;
    if (seq_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL seq_reseed: got %b expected 0", seq_err);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] next_word;
    reset_dut();
    wq.delete();
    next_word = DW'(1);
    for (int i = 0; i < 600; i++) begin
      m_ready    = $urandom_range(0, 3) != 0;
      hold_empty = $urandom_range(0, 3) == 0;
      if (wq.size() < 4) begin
        if ($urandom_range(0, 40) == 0) next_word = DW'($urandom);
        else if ($urandom_range(0, 30) == 0) next_word = DW'(1);
        wq.push_back(next_word);
        next_word = next_word + DW'(1);
      end
      rst = $urandom_range(0, 150) == 0;
      clk_cycle();
    end
    rst = 1'b0;
    hold_empty = 1'b0;
    m_ready = 1'b1;
    repeat (10) clk_cycle();
  endtask

  // Directed scenarios followed by a randomized soak, then the summary.
  initial begin
    ref_beats[0] = 24'h002001;
    ref_beats[1] = 24'h004003;
    ref_beats[2] = 24'h006005;
    ref_beats[3] = 24'h008007;
    rst = 1'b1;
    m_ready = 1'b0;
    hold_empty = 1'b0;
    fifo_rdempty = 1'b1;
    fifo_q = '0;
    model_reset();
    test_reset();
    test_full_rate();
    test_backpressure();
    test_empty_gaps();
    test_reset_mid();
    test_seq_check();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dcfifo_rd_packer.md
# dcfifo_rd_packer

Read-side drain stage for the show-ahead `dcfifo` (LPM_SHOWAHEAD = "ON"), running entirely in the FIFO read clock domain. It pops words from the FIFO whenever data is present and downstream space allows. It packs `PACK` consecutive words into one wide beat and presents the beats on a valid/ready stream, with `m_last` marking every `BURST_LEN`-th beat.

## Interface
Parameters:
- `DWIDTH`, 12: FIFO word width; matches dcfifo `LPM_WIDTH`.
- `PACK`, 2: words per output beat, ≥1.
- `BURST_LEN`, 16: beats per burst, ≥1; sets the `m_last` period.

Ports:
- `rdclk` in 1: FIFO read clock; the block's only clock.
- `rst` in 1: synchronous, active-high reset.
- `fifo_q` in DWIDTH: show-ahead head word; valid while `fifo_rdempty`=0.
- `fifo_rdempty` in 1: FIFO empty, read-side view.
- `fifo_rdreq` out 1: pop acknowledge; the head word is consumed in the same cycle.
- `m_data` out DWIDTH*PACK: packed beat; first-popped word in the LSBs, at lane i = bits [i*DWIDTH +: DWIDTH].
- `m_valid` out 1: beat valid.
- `m_ready` in 1: downstream accepts the beat.
- `m_last` out 1: last beat of a burst; qualified by `m_valid`.
- `beat_cnt` out 16: count of accepted beats (`m_valid && m_ready`).
- `seq_err` out 1: sticky sequence error; see Configuration.

## Operation
- Lane counter `lane`, range 0..PACK-1, indexes the next word slot. Accumulator holds lanes 0..PACK-2.
- `fifo_rdreq = !rst && !fifo_rdempty && (lane != PACK-1 || !m_valid || m_ready)`. This is combinational; there is a combinational path from `m_ready` to `fifo_rdreq`.
- Pop when lane < PACK-1: `fifo_q` is written into accumulator lane `lane`, and `lane` increments.
- Pop when lane = PACK-1:
  - The output register loads `{fifo_q, accumulator}`.
  - `m_valid` <= 1.
  - `m_last` <= (burst_idx == BURST_LEN-1).
  - burst_idx increments, wrapping from BURST_LEN-1 to 0.
  - `lane` <= 0.
- PACK=1: every pop forms a beat directly and the accumulator is absent.
- Output handshake:
  - Beat transfers when `m_valid && m_ready`.
  - If no new beat forms in that cycle, `m_valid` <= 0.
  - If a new beat forms in the same cycle, the register is overwritten and `m_valid` stays 1.
- Output stability: while `m_valid && !m_ready`, `m_data` and `m_last` are held constant. The accumulator may still fill lanes 0..PACK-2; the final-lane pop is blocked.
- `beat_cnt` increments on each transfer and wraps 0xFFFF→0.
- Word order is strictly preserved; no word is dropped or duplicated.

## Timing
- Reset values: `m_valid`=0, `m_last`=0, `m_data`=0, `beat_cnt`=0, `seq_err`=0, lane=0, burst_idx=0. `fifo_rdreq`=0 for as long as `rst` is high.
- Latency: the first beat's `m_valid` rises 1 cycle after the pop of its last word.
  - With the FIFO non-empty and `m_ready`=1, `m_valid` first rises at cycle PACK.
- Full rate is one word per cycle, i.e. one beat per PACK cycles. PACK=1 sustains one beat per cycle.
- Empty gaps: while `fifo_rdempty`=1, no pop occurs and lane/accumulator hold. A partial beat waits indefinitely.
- Reset mid-operation: a partial accumulator is discarded, and an un-transferred beat is discarded. Words already popped are lost by design.
- `rst` overrides everything in the same cycle.

## Configuration
- `DCFIFO_RD_SEQ_CHK_EN` defined: the sequence checker is compiled in.
  - Each popped word must equal previous popped word + 1, mod 2^DWIDTH.
  - A popped word of value 1 is always legal and re-seeds the sequence, matching a writer that restarts its count at 1.
  - The first pop after reset only seeds the reference value.
  - On a mismatch, `seq_err` <= 1 in the cycle after the offending pop. It stays high until `rst`.
- Not defined: no checker logic is generated and `seq_err` is tied to 0.

## Test plan
- PACK=2, BURST_LEN=4, FIFO preloaded with 1..8, `m_ready`=1:
  - `fifo_rdreq` is high for 8 consecutive cycles.
  - Beats are 0x002001, 0x004003, 0x006005, 0x008007.
  - `m_last` is set only on 0x008007.
  - `beat_cnt`=4 afterwards.
- Backpressure, `m_ready`=0 after beat 0x002001 forms:
  - Word 3 is popped into lane 0.
  - `fifo_rdreq` stays low with word 4 at the FIFO head.
  - `m_data` is stable.
  - After `m_ready`=1, the stream continues 0x004003… with no loss.
- `fifo_rdempty` toggling every other cycle:
  - Pops occur only while `fifo_rdempty`=0.
  - Beat contents and order are identical to the full-rate case.
- `rst` pulsed for 1 cycle after 3 words popped (PACK=2, BURST_LEN=4):
  - All outputs return to 0.
  - The next beat is built from fresh words starting at lane 0.
  - `m_last` next appears on the 4th subsequent beat.
- With `DCFIFO_RD_SEQ_CHK_EN` defined:
  - Sequence 1,2,3,5 sets `seq_err` 1 cycle after 5 is popped.
  - Sequence 1,2,3,1,2 keeps `seq_err`=0.
  - Without the macro, `seq_err` stays 0 for both sequences.
